apb_mem_slave_param: RTL and testbench
======================================

APB_MEM_SLAVE_PARAM -- requirements
Module: apb_mem_slave_param

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8: data bus width; multiple of 8, range 8..64.
REQ-002 SHALL have parameter ADDR_WIDTH, default 8: word address width.
REQ-003 SHALL have parameter DEPTH, default 256: memory words; at most 2**ADDR_WIDTH.
REQ-004 SHALL have parameter RD_WAIT, default 0: read wait states, range 0..15.
REQ-005 SHALL have parameter WR_WAIT, default 0: write wait states, range 0..15.
REQ-006 SHALL have port clk, input, 1: the only clock; all state changes on its rising edge.
REQ-007 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-008 SHALL have port sel, input, 1: APB slave select.
REQ-009 SHALL have port enable, input, 1: APB access phase.
REQ-010 SHALL have port write, input, 1: 1 = write, 0 = read.
REQ-011 SHALL have port addr, input, ADDR_WIDTH: word address.
REQ-012 SHALL have port wdata, input, DATA_WIDTH: write data.
REQ-013 SHALL have port strb, input, DATA_WIDTH/8: byte-lane write enables; strb[i] covers wdata[8i+7:8i].
REQ-014 SHALL have port rdata, output, DATA_WIDTH: read data.
REQ-015 SHALL have port ready, output, 1: transfer completes this cycle.
REQ-016 SHALL have port slverr, output, 1: completing transfer is in error; qualified by ready.

Function
REQ-017 SHALL implement an FSM with states IDLE and ACCESS.
REQ-018 Setup: on a rising edge with sel=1 and enable=0, the block SHALL take these actions.
- Latch addr, write, wdata and strb.
- Load the wait counter with WR_WAIT or RD_WAIT, chosen by write.
- Enter ACCESS.
REQ-019 Read data: on a setup edge with write=0 and addr<DEPTH, rdata SHALL be loaded with mem[addr]. Otherwise rdata SHALL load 0.
REQ-020 Wait states: in ACCESS, each edge with sel=1, enable=1 and counter>0 SHALL decrement the counter.
REQ-021 Ready: ready SHALL be combinational, equal to (state==ACCESS) & sel & enable & (counter==0).
REQ-022 Latency: with N wait states, ready SHALL assert in the (N+1)th access-phase cycle. Minimum transfer is 2 cycles (setup + access).
REQ-023 Completion: on an edge with ready=1 the transfer completes and the FSM SHALL return to IDLE.
REQ-024 Write commit: on the completing edge of a write, each memory byte lane with strb=1 SHALL update. Lanes with strb=0 SHALL be unchanged; strb=0 is legal and changes nothing.
REQ-025 Out of range: a latched addr>=DEPTH SHALL complete normally with ready and slverr=1 in the completing cycle, no memory change, and rdata=0.
REQ-026 Protocol error (enable without setup): sel=1 and enable=1 while in IDLE SHALL give ready=1 and slverr=1 combinationally, with no memory access and the FSM staying IDLE.
REQ-027 Abort: sel=0 sampled while in ACCESS SHALL return the FSM to IDLE with no write and no ready pulse.
REQ-028 A new setup edge (sel=1, enable=0) sampled while in ACCESS SHALL abandon the old transfer without writing and restart per REQ-018.
REQ-029 slverr SHALL be 0 whenever ready=0.
REQ-030 rdata SHALL hold its value between transfers until the next setup edge.

Reset
REQ-031 While reset=1, regardless of clk, the block SHALL immediately hold:
- FSM in IDLE, counter at 0, latched fields at 0;
- rdata=0, ready=0, slverr=0;
- all memory words at 0.
REQ-032 Reset asserted mid-transfer SHALL drop that transfer with no memory write.
REQ-033 Reset release SHALL take effect synchronously with clk, and the first setup edge after release SHALL be accepted.

Verification
REQ-034 Defaults: write 0x05 to addr 6, then read addr 6 -> ready on the 2nd cycle of each transfer, rdata=0x05, slverr=0.
REQ-035 Wait states, with WR_WAIT=5 and RD_WAIT=3: write 0x04 to addr 5 -> 5 access cycles with ready=0, then ready=1. Read addr 5 -> 3 cycles with ready=0, then ready=1 with rdata=0x04.
REQ-036 Strobes, with DATA_WIDTH=32:
- write 0xAABBCCDD to addr 2 with strb=1111;
- then write 0x11223344 to addr 2 with strb=0101;
- read addr 2 -> rdata=0xAA22CC44.
REQ-037 Errors, with DEPTH=16:
- write addr 20 -> ready=1, slverr=1, memory unchanged, and a read of addr 20 returns rdata=0 with slverr=1;
- sel=1 and enable=1 with no setup phase -> ready=1, slverr=1 in that cycle.
REQ-038 Abort and reset:
- write with WR_WAIT=3, drop sel after 1 access cycle -> addr keeps its old value;
- write with reset pulsed during the wait phase -> all outputs 0 and memory read back 0;
- after either case, the next transfer completes normally.

Source files
------------

// File: rtl/apb_mem_slave_param_if.sv
// APB slave bus bundle for apb_mem_slave_param.
//   master modport : drives sel/enable/write/addr/wdata/strb, observes rdata/ready/slverr
//   slave modport  : the mirror image
// clk and reset are deliberately kept out of the bundle.
interface apb_mem_slave_param_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8
);
  logic                    sel;
  logic                    enable;
  logic                    write;
  logic [ADDR_WIDTH-1:0]   addr;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] strb;
  logic [DATA_WIDTH-1:0]   rdata;
  logic                    ready;
  logic                    slverr;

  modport master (
    output sel, enable, write, addr, wdata, strb,
    input  rdata, ready, slverr
  );

  modport slave (
    input  sel, enable, write, addr, wdata, strb,
    output rdata, ready, slverr
  );
endinterface

// File: rtl/apb_mem_slave_param.sv
// APB memory slave with byte strobes and fixed read/write wait states.
//   clk    : single clock, rising edge
//   reset  : asynchronous, active-high; clears FSM, latches, rdata and memory
//   bus    : apb_mem_slave_param_if.slave (sel, enable, write, addr, wdata,
//            strb in; rdata, ready, slverr out)
// Setup phase latches the request and preloads rdata; the access phase counts
// down the wait states and completes with ready. Out-of-range addresses and
// enable-without-setup complete with slverr.
module apb_mem_slave_param #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8,
  parameter int DEPTH      = 256,
  parameter int RD_WAIT    = 0,
  parameter int WR_WAIT    = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  apb_mem_slave_param_if.slave  bus
);
  localparam int NB = DATA_WIDTH / 8;
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [3:0] RD_W = 4'(RD_WAIT);
  localparam logic [3:0] WR_W = 4'(WR_WAIT);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t                state, nxt;
  logic [3:0]            cnt;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  write_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [NB-1:0]         strb_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic setup, dec, commit, rdy, err;
  logic in_rng_in, in_rng_q;

  assign in_rng_in = {1'b0, bus.addr} < DEPTH_W;
  assign in_rng_q  = {1'b0, addr_q}   < DEPTH_W;

  // A setup cycle is recognised in any state; in ACCESS it abandons the
  // transfer in flight.
  assign setup = bus.sel & ~bus.enable;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= nxt;
  end

  always_comb begin
    nxt    = state;
    rdy    = 1'b0;
    err    = 1'b0;
    dec    = 1'b0;
    commit = 1'b0;
    case (state)
      IDLE: begin
        if (setup) nxt = ACCESS;
        else if (bus.sel && bus.enable) begin
          // enable without a setup phase: flag it, touch nothing
          rdy = 1'b1;
          err = 1'b1;
        end
      end
      ACCESS: begin
        if (!bus.sel)         nxt = IDLE;     // abort, no write
        else if (!bus.enable) nxt = ACCESS;   // restart via new setup
        else if (cnt != 4'd0) dec = 1'b1;
        else begin
          rdy    = 1'b1;
          err    = ~in_rng_q;
          commit = write_q & in_rng_q;
          nxt    = IDLE;
        end
      end
      default: nxt = IDLE;
    endcase
    if (reset) begin
      rdy    = 1'b0;
      err    = 1'b0;
      commit = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt     <= '0;
      addr_q  <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
      strb_q  <= '0;
      rdata_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (setup) begin
        addr_q  <= bus.addr;
        write_q <= bus.write;
        wdata_q <= bus.wdata;
        strb_q  <= bus.strb;
        cnt     <= bus.write ? WR_W : RD_W;
        // Read data is fetched at setup so it is stable through the access phase.
        rdata_q <= (!bus.write && in_rng_in) ? mem[bus.addr[IW-1:0]] : '0;
      end else if (dec) begin
        cnt <= cnt - 4'd1;
      end
      if (commit) begin
        for (int b = 0; b < NB; b++)
          if (strb_q[b]) mem[addr_q[IW-1:0]][8*b +: 8] <= wdata_q[8*b +: 8];
      end
    end
  end

  assign bus.rdata  = rdata_q;
  assign bus.ready  = rdy;
  assign bus.slverr = err;
endmodule

// File: tb/tb_apb_mem_slave_param.sv
module tb_apb_mem_slave_param;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int DEPTH = 16;
  localparam int RDW = 3;
  localparam int WRW = 5;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  logic [DW-1:0] mdl [DEPTH];

  apb_mem_slave_param_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  apb_mem_slave_param #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH),
    .RD_WAIT(RDW), .WR_WAIT(WRW)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  // Reference write: byte lanes selected by strb take the new data.
  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] d,
                                          input logic [DW/8-1:0] s);
    logic [DW-1:0] r;
    r = old;
    for (int b = 0; b < DW/8; b++)
      if (s[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  // One full transfer; reports the number of ready=0 access cycles seen.
  task automatic xfer(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                      input logic [DW/8-1:0] s, output int waits, output logic err,
                      output logic [DW-1:0] rd);
    @(negedge clk);
    bus.sel = 1'b1; bus.enable = 1'b0; bus.write = w;
    bus.addr = a; bus.wdata = d; bus.strb = s;
    @(negedge clk);
    bus.enable = 1'b1;
    waits = 0;
    #1;
    while (!bus.ready && waits < 40) begin
      chk("slverr_low_while_waiting", {31'd0, bus.slverr}, 32'd0);
      @(negedge clk); #1;
      waits++;
    end
    chk("ready_seen", {31'd0, bus.ready}, 32'd1);
    err = bus.slverr;
    rd  = bus.rdata;
    @(negedge clk);
    bus.sel = 1'b0; bus.enable = 1'b0;
  endtask

  // Transfer plus comparison against the model.
  task automatic do_check(input string tag, input logic w, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, input logic [DW/8-1:0] s);
    int waits; logic err; logic [DW-1:0] rd;
    logic oor;
    logic [DW-1:0] exp_rd;
    oor = (int'(a) >= DEPTH);
    exp_rd = (!w && !oor) ? mdl[a] : '0;
    xfer(w, a, d, s, waits, err, rd);
    chk({tag, "_waits"}, waits, w ? WRW : RDW);
    chk({tag, "_slverr"}, {31'd0, err}, {31'd0, oor});
    chk({tag, "_rdata"}, rd, exp_rd);
    if (w && !oor) mdl[a] = merge(mdl[a], d, s);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] hold;
    bus.sel = 1'b0; bus.enable = 1'b0; bus.write = 1'b0;
    bus.addr = '0; bus.wdata = '0; bus.strb = '0;
    for (int i = 0; i < DEPTH; i++) mdl[i] = '0;

    // Reset: outputs held low even with an access-phase pattern on the bus.
    reset = 1'b1;
    #2;
    bus.sel = 1'b1; bus.enable = 1'b1;
    #1;
    chk("rst_ready",  {31'd0, bus.ready},  32'd0);
    chk("rst_slverr", {31'd0, bus.slverr}, 32'd0);
    chk("rst_rdata",  bus.rdata, 32'd0);
    @(negedge clk);
    bus.sel = 1'b0; bus.enable = 1'b0;
    reset = 1'b0;

    // Basic write/read, wait-state counts, strobes.
    do_check("wr6", 1'b1, 5'd6, 32'h05, 4'hF);
    do_check("rd6", 1'b0, 5'd6, 32'h0, 4'h0);
    do_check("wr5", 1'b1, 5'd5, 32'h04, 4'hF);
    do_check("rd5", 1'b0, 5'd5, 32'h0, 4'h0);
    do_check("wr2a", 1'b1, 5'd2, 32'hAABBCCDD, 4'b1111);
    do_check("wr2b", 1'b1, 5'd2, 32'h11223344, 4'b0101);
    do_check("rd2", 1'b0, 5'd2, 32'h0, 4'h0);
    chk("strobe_merge_value", mdl[2], 32'hAA22CC44);
    do_check("wr2_nostrb", 1'b1, 5'd2, 32'hFFFFFFFF, 4'b0000);
    do_check("rd2_nostrb", 1'b0, 5'd2, 32'h0, 4'h0);

    // rdata holds while idle.
    hold = bus.rdata;
    repeat (3) @(negedge clk);
    chk("rdata_hold", bus.rdata, hold);

    // Out of range.
    do_check("wr20", 1'b1, 5'd20, 32'h12345678, 4'hF);
    do_check("rd20", 1'b0, 5'd20, 32'h0, 4'h0);

    // Enable without setup.
    @(negedge clk);
    bus.sel = 1'b1; bus.enable = 1'b1; bus.write = 1'b1; bus.addr = 5'd6;
    bus.wdata = 32'hFFFFFFFF; bus.strb = 4'hF;
    #1;
    chk("proto_ready",  {31'd0, bus.ready},  32'd1);
    chk("proto_slverr", {31'd0, bus.slverr}, 32'd1);
    @(negedge clk);
    bus.sel = 1'b0; bus.enable = 1'b0;
    do_check("rd6_after_proto", 1'b0, 5'd6, 32'h0, 4'h0);

    // Randomized traffic.
    for (int i = 0; i < 24; i++) begin
      logic w; logic [AW-1:0] a;
      w = 1'($urandom_range(0, 1));
      a = AW'($urandom_range(0, 19));
      do_check("rand", w, a, $urandom, 4'($urandom));
    end

    // Abort: sel dropped after one access cycle leaves memory alone.
    do_check("wr7", 1'b1, 5'd7, 32'h12345678, 4'hF);
    @(negedge clk);
    bus.sel = 1'b1; bus.enable = 1'b0; bus.write = 1'b1;
    bus.addr = 5'd7; bus.wdata = 32'hDEADBEEF; bus.strb = 4'hF;
    @(negedge clk);
    bus.enable = 1'b1;
    #1;
    chk("abort_ready_access", {31'd0, bus.ready}, 32'd0);
    @(negedge clk);
    bus.sel = 1'b0; bus.enable = 1'b0;
    #1;
    chk("abort_ready_drop", {31'd0, bus.ready}, 32'd0);
    do_check("rd7_after_abort", 1'b0, 5'd7, 32'h0, 4'h0);

    // Restart: a new setup mid-access abandons the pending write.
    @(negedge clk);
    bus.sel = 1'b1; bus.enable = 1'b0; bus.write = 1'b1;
    bus.addr = 5'd7; bus.wdata = 32'h0BADF00D; bus.strb = 4'hF;
    @(negedge clk);
    bus.enable = 1'b1;
    do_check("rd7_after_restart", 1'b0, 5'd7, 32'h0, 4'h0);

    // Reset during wait states.
    @(negedge clk);
    bus.sel = 1'b1; bus.enable = 1'b0; bus.write = 1'b1;
    bus.addr = 5'd3; bus.wdata = 32'hCAFEF00D; bus.strb = 4'hF;
    @(negedge clk);
    bus.enable = 1'b1;
    #2;
    reset = 1'b1;
    #1;
    chk("midrst_ready",  {31'd0, bus.ready},  32'd0);
    chk("midrst_slverr", {31'd0, bus.slverr}, 32'd0);
    chk("midrst_rdata",  bus.rdata, 32'd0);
    @(negedge clk);
    bus.sel = 1'b0; bus.enable = 1'b0;
    reset = 1'b0;
    for (int i = 0; i < DEPTH; i++) mdl[i] = '0;
    do_check("rd3_after_rst", 1'b0, 5'd3, 32'h0, 4'h0);
    do_check("rd2_after_rst", 1'b0, 5'd2, 32'h0, 4'h0);
    do_check("wr9_after_rst", 1'b1, 5'd9, 32'h5A5AA5A5, 4'hF);
    do_check("rd9_after_rst", 1'b0, 5'd9, 32'h0, 4'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
